vga_frame_reader: RTL
=====================

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 1024: active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 768: active lines per frame.
REQ-003 SHALL have parameter BURST, default 16: master burst length in words (power of 2, 1..64).
REQ-004 SHALL have parameter FIFO_DEPTH, default 64: pixel FIFO depth in words (power of 2, >= 2*BURST).
REQ-005 SHALL have these ports: clk  in  1  single clock (kernel/video fabric clock); all logic on rising edge.
REQ-006 SHALL have these ports: reset  in  1  asynchronous, active-high.
REQ-007 SHALL have these ports: csr_address  in  2; csr_write  in  1; csr_writedata  in  32; csr_read  in  1; csr_readdata  out  32 (Avalon-MM slave, fixed read latency 1).
REQ-008 SHALL have these ports: m_address  out  32; m_read  out  1; m_burstcount  out  7; m_waitrequest  in  1; m_readdata  in  32; m_readdatavalid  in  1 (Avalon-MM burst read master into shared HPS memory).
REQ-009 SHALL have these ports: st_data  out  32; st_valid  out  1; st_ready  in  1; st_sop  out  1; st_eop  out  1 (Avalon-ST video source to clocked-video output).
REQ-010 SHALL have these ports: irq  out  1  level interrupt.

Function
REQ-011 SHALL decode CSR words as: 0 CONTROL (bit0 enable, bit1 irq_en); 1 STATUS (bit0 busy, bit1 swap_pending, bit2 irq_flag; write 1 to bit2 clears it); 2 FRONT (frame base, bytes); 3 BACK (write arms swap).
REQ-012 SHALL accept a FRONT write only while busy=0 and ignore it otherwise.
REQ-013 SHALL, on a BACK write, latch the address and set swap_pending; a second write before the swap overwrites the address.
REQ-014 SHALL sequence frames with FSM IDLE -> HEADER -> STREAM -> IDLE/HEADER.
REQ-015 SHALL leave IDLE for HEADER when enable=1, latching FRONT as frame base and setting busy=1.
REQ-016 SHALL, in HEADER, drive st_valid=1, st_sop=1, st_data=0 (video packet type), and move to STREAM on st_ready.
REQ-017 SHALL, in STREAM, emit exactly WIDTH*HEIGHT pixel beats from the FIFO in address order, with st_valid = FIFO not empty, st_eop=1 on the last beat only, and st_sop=0.
REQ-018 SHALL hold st_data/st_sop/st_eop stable while st_valid=1 and st_ready=0.
REQ-019 SHALL issue read bursts from frame base upward in steps of BURST*4 bytes, with m_burstcount=BURST, the final burst shortened to the remaining words.
REQ-020 SHALL issue a burst only when fifo_used + outstanding_words + burstcount <= FIFO_DEPTH, so the FIFO never overflows.
REQ-021 SHALL hold m_read/m_address/m_burstcount while m_waitrequest=1; a burst is accepted on the cycle m_read=1 and m_waitrequest=0.
REQ-022 SHALL, at last-beat acceptance, when swap_pending=1, set FRONT<=BACK, clear swap_pending, set irq_flag; irq = irq_flag & irq_en.
REQ-023 SHALL, at last-beat acceptance, go to HEADER when enable=1 and to IDLE with busy=0 otherwise; clearing enable mid-frame completes the current frame.
REQ-024 SHALL apply a CSR swap-arm in the same cycle as a frame end to the next frame end.
REQ-025 SHALL count pixels and words issued in widths sufficient for WIDTH*HEIGHT, with no wrap inside a frame.

Reset
REQ-026 SHALL, on reset assertion, immediately enter IDLE and force all of the following to 0: st_valid, st_sop, st_eop, m_read, irq, csr_readdata, CONTROL, STATUS, FRONT, BACK, FIFO, counters and outstanding count.
REQ-027 SHALL discard any read data in flight at reset.

Verification (WIDTH=4, HEIGHT=2, BURST=4, FIFO_DEPTH=8)
REQ-028 SHALL pass this scenario: FRONT=0x1000, enable=1, st_ready=1, zero-wait memory -> reads at 0x1000 and 0x1010, burstcount 4 each; header beat 0 with sop, then 8 pixels in order, eop on the 8th.
REQ-029 SHALL pass this scenario: st_ready held 0 after the header -> at most 8 words outstanding+buffered; no further m_read until a pixel is consumed.
REQ-030 SHALL pass this scenario: BACK=0x2000 written mid-frame, irq_en=1 -> after eop, STATUS bit1=0, bit2=1, irq=1; next frame reads from 0x2000; write STATUS=4 -> irq=0.
REQ-031 SHALL pass this scenario: enable cleared during pixel 3 -> frame completes through eop, then busy=0, no new header.
REQ-032 SHALL pass this scenario: m_waitrequest=1 for 5 cycles on the first burst -> address/burstcount stable, total pixel count still 8.
REQ-033 SHALL pass this scenario: reset asserted mid-frame with data in flight -> all outputs 0 at once; after release and enable, a fresh frame starts with a header from the new FRONT.

Source files
------------

// File: rtl/vga_frame_reader.sv
// Frame-buffer scan-out engine: burst-reads a frame from shared memory into a
// pixel FIFO and sources it as an Avalon-ST video packet, with CSR-driven double buffering.
module vga_frame_reader #(
   parameter int WIDTH      = 1024,
   parameter int HEIGHT     = 768,
   parameter int BURST      = 16,
   parameter int FIFO_DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  csr_address,
   input  logic        csr_write,
   input  logic [31:0] csr_writedata,
   input  logic        csr_read,
   output logic [31:0] csr_readdata,
   output logic [31:0] m_address,
   output logic        m_read,
   output logic [6:0]  m_burstcount,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   input  logic        m_readdatavalid,
   output logic [31:0] st_data,
   output logic        st_valid,
   input  logic        st_ready,
   output logic        st_sop,
   output logic        st_eop,
   output logic        irq
);
   localparam int TOTAL = WIDTH * HEIGHT;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int UW    = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_STREAM} state_t;

   state_t          state_reg;
   logic            enable_reg, irq_en_reg, busy_reg, swap_pending_reg, irq_flag_reg;
   logic [31:0]     front_reg, back_reg, base_reg;
   logic [CW-1:0]   pix_cnt_reg, words_issued_reg;
   logic [UW-1:0]   outstanding_reg, used_reg;
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [31:0]     fifo_mem [FIFO_DEPTH];

   logic [CW-1:0]   words_left;
   logic [6:0]      burst_len;
   logic [31:0]     fill_need;
   logic            can_issue, accept, push, pop, last_pix, last_beat, set_irq;

   assign words_left = CW'(TOTAL) - words_issued_reg;
   assign burst_len  = (32'(words_left) >= BURST) ? 7'(BURST) : 7'(words_left);
   // Space is reserved for every requested word, so the FIFO can never overflow.
   assign fill_need  = 32'(used_reg) + 32'(outstanding_reg) + 32'(burst_len);
   assign can_issue  = (state_reg != S_IDLE) && !m_read &&
                       (words_issued_reg != CW'(TOTAL)) && (fill_need <= FIFO_DEPTH);
   assign accept     = m_read && !m_waitrequest;
   // Returning data with nothing outstanding is stale (issued before a reset).
   assign push       = m_readdatavalid && (outstanding_reg != '0);
   assign pop        = (state_reg == S_STREAM) && (used_reg != '0) && st_ready;
   assign last_pix   = (pix_cnt_reg == CW'(TOTAL - 1));
   assign last_beat  = pop && last_pix;
   assign set_irq    = last_beat && swap_pending_reg;

   assign st_valid = (state_reg == S_HEADER) || ((state_reg == S_STREAM) && (used_reg != '0));
   assign st_sop   = (state_reg == S_HEADER);
   assign st_eop   = (state_reg == S_STREAM) && (used_reg != '0) && last_pix;
   assign st_data  = (state_reg == S_STREAM) ? fifo_mem[rd_ptr_reg] : 32'd0;
   assign irq      = irq_flag_reg && irq_en_reg;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= m_readdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= S_IDLE;
         enable_reg       <= 1'b0;
         irq_en_reg       <= 1'b0;
         busy_reg         <= 1'b0;
         swap_pending_reg <= 1'b0;
         irq_flag_reg     <= 1'b0;
         front_reg        <= '0;
         back_reg         <= '0;
         base_reg         <= '0;
         pix_cnt_reg      <= '0;
         words_issued_reg <= '0;
         outstanding_reg  <= '0;
         used_reg         <= '0;
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         m_read           <= 1'b0;
         m_address        <= '0;
         m_burstcount     <= '0;
         csr_readdata     <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (enable_reg) begin
                  state_reg        <= S_HEADER;
                  base_reg         <= front_reg;
                  busy_reg         <= 1'b1;
                  pix_cnt_reg      <= '0;
                  words_issued_reg <= '0;
               end
            end
            S_HEADER: begin
               if (st_ready) state_reg <= S_STREAM;
            end
            S_STREAM: begin
               if (pop) pix_cnt_reg <= pix_cnt_reg + CW'(1);
               if (last_beat) begin
                  if (swap_pending_reg) begin
                     front_reg        <= back_reg;
                     swap_pending_reg <= 1'b0;
                     irq_flag_reg     <= 1'b1;
                  end
                  if (enable_reg) begin
                     state_reg        <= S_HEADER;
                     base_reg         <= swap_pending_reg ? back_reg : front_reg;
                     pix_cnt_reg      <= '0;
                     words_issued_reg <= '0;
                  end else begin
                     state_reg <= S_IDLE;
                     busy_reg  <= 1'b0;
                  end
               end
            end
            default: state_reg <= S_IDLE;
         endcase

         if (accept) m_read <= 1'b0;
         if (can_issue) begin
            m_read           <= 1'b1;
            m_address        <= base_reg + (32'(words_issued_reg) << 2);
            m_burstcount     <= burst_len;
            words_issued_reg <= words_issued_reg + CW'(burst_len);
         end

         outstanding_reg <= outstanding_reg + (accept ? UW'(m_burstcount) : '0) - (push ? UW'(1) : '0);
         used_reg        <= used_reg + (push ? UW'(1) : '0) - (pop ? UW'(1) : '0);
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);

         if (csr_read) begin
            case (csr_address)
               2'd0:    csr_readdata <= {30'd0, irq_en_reg, enable_reg};
               2'd1:    csr_readdata <= {29'd0, irq_flag_reg, swap_pending_reg, busy_reg};
               2'd2:    csr_readdata <= front_reg;
               default: csr_readdata <= back_reg;
            endcase
         end
         // Placed after the frame-end logic: a same-cycle BACK write arms the next swap.
         if (csr_write) begin
            case (csr_address)
               2'd0: begin
                  enable_reg <= csr_writedata[0];
                  irq_en_reg <= csr_writedata[1];
               end
               2'd1: if (csr_writedata[2] && !set_irq) irq_flag_reg <= 1'b0;
               2'd2: if (!busy_reg) front_reg <= csr_writedata;
               default: begin
                  back_reg         <= csr_writedata;
                  swap_pending_reg <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule
